// File: rtl/control_unit.sv
// Multi-cycle control unit: two-byte fetch (T0/T1), then decode and execute from T2.
// Compile-time option CU_ILLEGAL_TRAP_EN makes undefined opcodes halt instead of acting as NOPs.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic        ALU_WF,
  output logic [4:0]  ALU_FunSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic [2:0]  Seq,
  output logic        Halted
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 2;

  localparam logic [OP_W-1:0] OP_BRA  = 6'h00;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h01;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h02;
  localparam logic [OP_W-1:0] OP_MOVL = 6'h03;
  localparam logic [OP_W-1:0] OP_ADD  = 6'h04;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h05;
  localparam logic [OP_W-1:0] OP_AND  = 6'h06;
  localparam logic [OP_W-1:0] OP_ORR  = 6'h07;
  localparam logic [OP_W-1:0] OP_STR  = 6'h08;
  localparam logic [OP_W-1:0] OP_LDR  = 6'h09;
  localparam logic [OP_W-1:0] OP_HLT  = 6'h3F;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} t_state_e;

  t_state_e          r_t;
  logic              r_halted;

  logic [OP_W-1:0]   w_op;
  logic [REG_W-1:0]  w_rd;
  logic [REG_W-1:0]  w_rs1;
  logic [REG_W-1:0]  w_rs2;
  logic [3:0]        w_rd_onehot;
  logic              w_z;
  logic              w_is_str;
  logic              w_is_ldr;
  logic              w_undef;
  logic              w_halt_op;
  logic              w_unused_bits;

  assign w_op          = IROut[15:10];
  assign w_rd          = IROut[9:8];
  assign w_rs1         = IROut[7:6];
  assign w_rs2         = IROut[5:4];
  assign w_rd_onehot   = 4'b0001 << w_rd;
  assign w_z           = Flags[3];
  assign w_is_str      = (w_op == OP_STR);
  assign w_is_ldr      = (w_op == OP_LDR);
  assign w_undef       = (w_op > OP_LDR) && (w_op != OP_HLT);
  assign w_halt_op     = (w_op == OP_HLT) || (TRAP_EN && w_undef);
  assign w_unused_bits = ^{Flags[2:0], IROut[3:0]};

  assign Seq    = r_t;
  assign Halted = r_halted;

  // Sequence counter and halt latch; a halted core stays frozen at T0 until reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_t      <= T0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      case (r_t)
        T0: r_t <= T1;
        T1: r_t <= T2;
        T2: begin
          r_t      <= (w_is_str || w_is_ldr) ? T3 : T0;
          r_halted <= w_halt_op;
        end
        T3: r_t <= T4;
        T4: r_t <= T5;
        T5: r_t <= w_is_ldr ? T6 : T0;
        default: r_t <= T0;
      endcase
    end
  end

  // Control word decode from step, halt state and instruction.
  always_comb begin
    ALU_WF      = 1'b0;
    ALU_FunSel  = 5'b00000;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    ARF_OutDSel = 2'b00;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    IR_Write    = 1'b0;
    IR_LH       = 1'b0;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;

    if (!Reset && !r_halted) begin
      case (r_t)
        T0, T1: begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (r_t == T1);
          ARF_FunSel = 2'b01;
          ARF_RegSel = 3'b100;
        end
        T2, T3, T4, T5: begin
          if (w_is_str) begin
            // Byte order is MSB first, so the byte select counts down 3..0.
            ALU_FunSel  = 5'b10000;
            RF_OutASel  = {1'b0, w_rs1};
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
            MuxCSel     = 2'(3'd5 - 3'(r_t));
            ARF_FunSel  = 2'b01;
            ARF_RegSel  = 3'b010;
          end else if (w_is_ldr) begin
            DR_E        = 1'b1;
            DR_FunSel   = 2'b10;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            ARF_FunSel  = 2'b01;
            ARF_RegSel  = 3'b010;
          end else if (r_t == T2) begin
            case (w_op)
              OP_BRA, OP_BNE, OP_BEQ: begin
                if ((w_op == OP_BRA) || ((w_op == OP_BNE) && !w_z) ||
                    ((w_op == OP_BEQ) && w_z)) begin
                  MuxBSel    = 2'b11;
                  ARF_FunSel = 2'b10;
                  ARF_RegSel = 3'b100;
                end
              end
              OP_MOVL: begin
                MuxASel   = 2'b11;
                RF_FunSel = 3'b010;
                RF_RegSel = w_rd_onehot;
              end
              OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                case (w_op)
                  OP_ADD:  ALU_FunSel = 5'b10100;
                  OP_SUB:  ALU_FunSel = 5'b10110;
                  OP_AND:  ALU_FunSel = 5'b10111;
                  default: ALU_FunSel = 5'b11000;
                endcase
                ALU_WF     = 1'b1;
                RF_OutASel = {1'b0, w_rs1};
                RF_OutBSel = {1'b0, w_rs2};
                RF_FunSel  = 3'b010;
                RF_RegSel  = w_rd_onehot;
              end
              default: ;
            endcase
          end
        end
        T6: begin
          if (w_is_ldr) begin
            MuxASel   = 2'b10;
            RF_FunSel = 3'b010;
            RF_RegSel = w_rd_onehot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction expands into a queue of expected per-cycle control words.
module tb_control_unit;

  typedef struct packed {
    logic       alu_wf;
    logic [4:0] alu_fun;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic [1:0] arf_d;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic [1:0] mux_c;
    logic       mux_d;
    logic       mem_cs;
    logic       mem_wr;
    logic       ir_wr;
    logic       ir_lh;
    logic       dr_e;
    logic [1:0] dr_fun;
    logic [2:0] seq;
    logic       halted;
  } ctl_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic        ALU_WF;
  logic [4:0]  ALU_FunSel;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_OutDSel, MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E;
  logic [1:0]  DR_FunSel;
  logic [2:0]  Seq;
  logic        Halted;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
    .ALU_WF(ALU_WF), .ALU_FunSel(ALU_FunSel), .RF_OutASel(RF_OutASel),
    .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .ARF_OutDSel(ARF_OutDSel),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Write(IR_Write), .IR_LH(IR_LH),
    .DR_E(DR_E), .DR_FunSel(DR_FunSel), .Seq(Seq), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int   vectors = 0;
  int   errors  = 0;
  int   cycle_n = 0;
  ctl_t exp_cur;
  logic exp_valid = 1'b0;
  ctl_t exp_q[$];

  function automatic ctl_t idle(input logic [2:0] s, input logic h);
    ctl_t w;
    w = '0;
    w.mem_cs = 1'b1;
    w.seq    = s;
    w.halted = h;
    return w;
  endfunction

  function automatic ctl_t fetch(input logic lh);
    ctl_t w;
    w = idle(3'(lh), 1'b0);
    w.mem_cs  = 1'b0;
    w.ir_wr   = 1'b1;
    w.ir_lh   = lh;
    w.arf_fun = 2'b01;
    w.arf_reg = 3'b100;
    return w;
  endfunction

  function automatic logic halts(input logic [5:0] op);
    return (op == 6'h3F) || (TRAP_EN && op > 6'h09);
  endfunction

  // Expand one instruction into the control words it must produce, cycle by cycle.
  task automatic build(input logic [15:0] ir, input logic [3:0] fl);
    logic [5:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [4:0] alu_tab [4];
    ctl_t       w;
    op  = ir[15:10];
    rd  = ir[9:8];
    rs1 = ir[7:6];
    rs2 = ir[5:4];
    alu_tab[0] = 5'b10100; alu_tab[1] = 5'b10110;
    alu_tab[2] = 5'b10111; alu_tab[3] = 5'b11000;
    exp_q.delete();
    exp_q.push_back(fetch(1'b0));
    exp_q.push_back(fetch(1'b1));
    w = idle(3'd2, 1'b0);
    if (op <= 6'h02) begin
      if (op == 6'h00 || (op == 6'h01 && !fl[3]) || (op == 6'h02 && fl[3])) begin
        w.mux_b = 2'b11; w.arf_fun = 2'b10; w.arf_reg = 3'b100;
      end
      exp_q.push_back(w);
    end else if (op == 6'h03) begin
      w.mux_a = 2'b11; w.rf_fun = 3'b010; w.rf_reg = 4'(1 << rd);
      exp_q.push_back(w);
    end else if (op <= 6'h07) begin
      w.alu_fun = alu_tab[op - 6'h04]; w.alu_wf = 1'b1;
      w.out_a = {1'b0, rs1}; w.out_b = {1'b0, rs2};
      w.rf_fun = 3'b010; w.rf_reg = 4'(1 << rd);
      exp_q.push_back(w);
    end else if (op == 6'h08 || op == 6'h09) begin
      for (int k = 0; k < 4; k++) begin
        w = idle(3'(2 + k), 1'b0);
        w.arf_d = 2'b10; w.mem_cs = 1'b0; w.arf_fun = 2'b01; w.arf_reg = 3'b010;
        if (op == 6'h08) begin
          w.alu_fun = 5'b10000; w.out_a = {1'b0, rs1}; w.mem_wr = 1'b1;
          w.mux_c = 2'(3 - k);
        end else begin
          w.dr_e = 1'b1; w.dr_fun = 2'b10;
        end
        exp_q.push_back(w);
      end
      if (op == 6'h09) begin
        w = idle(3'd6, 1'b0);
        w.mux_a = 2'b10; w.rf_fun = 3'b010; w.rf_reg = 4'(1 << rd);
        exp_q.push_back(w);
      end
    end else begin
      exp_q.push_back(w);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic rst, input logic [15:0] ir, input logic [3:0] fl,
                     input ctl_t e, input logic v);
    Reset = rst; IROut = ir; Flags = fl; exp_cur = e; exp_valid = v;
    @(posedge Clock);
    #1;
    cycle_n++;
  endtask

  // Run one instruction; reset_at >= 0 asserts Reset at that step of the instruction.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input int reset_at);
    build(ir, fl);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == reset_at) begin
        cyc(1'b1, ir, fl, idle(exp_q[i].seq, 1'b0), 1'b1);
        return;
      end
      cyc(1'b0, ir, fl, exp_q[i], 1'b1);
    end
    if (halts(ir[15:10])) begin
      repeat (3) cyc(1'b0, 16'($urandom), 4'($urandom), idle(3'd0, 1'b1), 1'b1);
      cyc(1'b1, ir, fl, idle(3'd0, 1'b1), 1'b1);
    end
  endtask

  // Single compare process: DUT control word versus the model, sampled on the falling edge.
  always @(negedge Clock) begin
    ctl_t act;
    if (exp_valid) begin
      act = '{ALU_WF, ALU_FunSel, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel,
              ARF_FunSel, ARF_RegSel, ARF_OutDSel, MuxASel, MuxBSel, MuxCSel,
              MuxDSel, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E, DR_FunSel, Seq, Halted};
      vectors++;
      if (act !== exp_cur) begin
        errors++;
        $display("FAIL ctl cyc=%0d ir=%h rst=%b actual=%h required=%h",
                 cycle_n, IROut, Reset, act, exp_cur);
      end
    end
  end

  initial begin
    logic [5:0]  op;
    logic [15:0] ir;
    int          rat;
    Reset = 1'b1; IROut = 16'h0000; Flags = 4'h0;
    #1;

    build(16'h0C42, 4'h0);
    chk("movl_len",   64'(exp_q.size()), 64'd3);
    chk("movl_muxa",  64'(exp_q[2].mux_a), 64'h3);
    chk("movl_rfreg", 64'(exp_q[2].rf_reg), 64'h1);
    chk("movl_rffun", 64'(exp_q[2].rf_fun), 64'h2);
    build(16'h1160, 4'h0);
    chk("add_alu",  64'(exp_q[2].alu_fun), 64'h14);
    chk("add_outa", 64'(exp_q[2].out_a), 64'h1);
    chk("add_outb", 64'(exp_q[2].out_b), 64'h2);
    chk("add_reg",  64'(exp_q[2].rf_reg), 64'h2);
    build(16'h2400, 4'h0);
    chk("ldr_len",  64'(exp_q.size()), 64'd7);
    chk("ldr_t6a",  64'(exp_q[6].mux_a), 64'h2);
    build(16'h2000, 4'h0);
    chk("str_len",  64'(exp_q.size()), 64'd6);
    chk("str_muxc", 64'(exp_q[5].mux_c), 64'h0);

    cyc(1'b1, 16'h0000, 4'h0, idle(3'd0, 1'b0), 1'b0);
    cyc(1'b1, 16'h0000, 4'h0, idle(3'd0, 1'b0), 1'b1);

    run_instr(16'h0C42, 4'h0, -1);
    run_instr(16'h1160, 4'h0, -1);
    run_instr(16'h0455, 4'b1000, -1);
    run_instr(16'h0455, 4'b0000, -1);
    run_instr(16'h0833, 4'b1000, -1);
    run_instr(16'h27C0, 4'h0, -1);
    run_instr(16'h2140, 4'h0, 4);
    run_instr(16'h2140, 4'h0, -1);
    run_instr(16'hF800, 4'h0, -1);
    run_instr(16'hFC00, 4'h0, -1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) op = 6'($urandom_range(0, 9));
      else                           op = 6'($urandom_range(0, 63));
      ir  = {op, 10'($urandom)};
      rat = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(ir, 4'($urandom), rat);
    end

    exp_valid = 1'b0;
    @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters.
REQ-002 Clock  in  1  single system clock; all state updates on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 IROut  in  16  instruction register contents.
REQ-005 Flags  in  4  ALU flags {Z,C,N,O}, bit 3 = Z.
REQ-006 ALU_WF  out  1  ALU flag write enable.
REQ-007 ALU_FunSel  out  5  ALU op: 10000 pass A, 10100 ADD, 10110 SUB, 10111 AND, 11000 ORR.
REQ-008 RF_OutASel / RF_OutBSel  out  3 each  RF read selects, 000..011 = R1..R4.
REQ-009 RF_FunSel  out  3  010 load, 000 hold.
REQ-010 RF_RegSel  out  4  one-hot write enable, bit0 = R1 (1 = write).
REQ-011 ARF_FunSel  out  2  01 increment, 10 load.
REQ-012 ARF_RegSel  out  3  {PC,AR,SP} write enables (1 = write).
REQ-013 ARF_OutDSel  out  2  address source: 00 PC, 10 AR.
REQ-014 MuxASel / MuxBSel  out  2 each  00 ALUOut, 01 OutC, 10 DROut, 11 IR[7:0].
REQ-015 MuxCSel  out  2  selects the memory write byte, 00 = ALUOut[7:0].
REQ-016 MuxDSel  out  1  ALU A source, 0 = OutA.
REQ-017 Mem_CS  out  1  memory select, active-low.
REQ-018 Mem_WR  out  1  1 = write, 0 = read.
REQ-019 IR_Write / IR_LH  out  1 each  IR load enable; LH = 0 loads the low byte, 1 loads the high byte.
REQ-020 DR_E  out  1  data register enable.
REQ-021 DR_FunSel  out  2  10 = shift left 8 and load byte into [7:0].
REQ-022 Seq  out  3  current sequence counter T.
REQ-023 Halted  out  1  high while halted.

Function
REQ-024 Control outputs SHALL be combinational from T, the halted state and IROut.
- Idle value: all enables 0, Mem_CS = 1, all selects 0, FunSels hold.
REQ-025 T0 fetch-low: ARF_OutDSel = 00, Mem_CS = 0, Mem_WR = 0, IR_Write = 1, IR_LH = 0, PC incremented.
REQ-026 T1 fetch-high: same as T0 with IR_LH = 1.
REQ-027 Decode from T2 on: op = IR[15:10], Rd = IR[9:8], Rs1 = IR[7:6], Rs2 = IR[5:4].
REQ-028 op 00 BRA: at T2, PC <- {8'h00, IR[7:0]} (MuxBSel = 11, ARF load PC).
REQ-029 op 01 BNE / op 02 BEQ: same as BRA when Z == 0 / Z == 1; otherwise no write.
REQ-030 op 03 MOVL: at T2, Rd <- zero-extended IR[7:0] (MuxASel = 11).
REQ-031 ops 04/05/06/07 (ADD/SUB/AND/ORR): at T2, Rd <- Rs1 op Rs2.
- ALU_WF = 1, MuxASel = 00.
REQ-032 op 08 STR, T2..T5: write ALU pass-A of Rs1 to M[AR], MSB first.
- MuxCSel = 11, 10, 01, 00 in that order.
- AR incremented every cycle.
REQ-033 op 09 LDR, T2..T5: DR_E = 1, DR_FunSel = 10, read M[AR], AR incremented every cycle.
- T6: Rd <- DROut (MuxASel = 10).
REQ-034 T SHALL return to 0 after the last step.
- Latencies: BRA/Bxx/MOVL/ALU 3 cycles, STR 6, LDR 7.
- T never exceeds 6.
REQ-035 op 3F HLT: at T2 enter halted state.
- While halted: outputs idle, T holds 0, Halted = 1, no fetch until Reset.
REQ-036 Undefined opcodes: see REQ-040 and REQ-041.

Reset
REQ-037 Reset high SHALL force outputs idle in the same cycle, and T = 0 and Halted = 0 on the next edge.
REQ-038 Reset mid-instruction SHALL abandon the instruction; bytes already written stay written, and the first cycle after Reset is T0.

Configuration
REQ-039 Macro CU_ILLEGAL_TRAP_EN SHALL select how undefined opcodes are handled.
REQ-040 With CU_ILLEGAL_TRAP_EN defined: an undefined opcode at T2 enters the halted state.
REQ-041 Without CU_ILLEGAL_TRAP_EN: an undefined opcode is a 3-cycle NOP with no writes at T2.

Verification
REQ-042 Reset, then IROut = 16'h0C42 at T2 (MOVL R1, 8'h42) -> T2: MuxASel = 11, RF_RegSel = 0001, RF_FunSel = 010; Seq returns to 0.
REQ-043 IROut = 16'h1160 (ADD R2, R2, R3) -> T2: ALU_FunSel = 10100, RF_OutASel = 001, RF_OutBSel = 010, ALU_WF = 1, RF_RegSel = 0010.
REQ-044 BNE with Flags = 4'b1000 -> no ARF write at T2; with Flags = 0 -> ARF_RegSel = 100, ARF_FunSel = 10.
REQ-045 LDR -> T2..T5: Mem_CS = 0, DR_E = 1, ARF_OutDSel = 10; T6: MuxASel = 10; 7 cycles total.
REQ-046 Reset asserted at T4 of STR -> outputs idle immediately; next cycle Seq = 0 with a fetch.
REQ-047 IROut op 3E -> Halted = 1 with CU_ILLEGAL_TRAP_EN defined; without it, no writes and T0 fetch resumes.
